// File: rtl/spmv_result_packer_pkg.sv
// Shared definitions for the SpMV result packer: precision codes, FSM states and lane math.
package spmv_pack_pkg;

  localparam logic [1:0] MODE_HALF   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_DOUBLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic int unsigned lanes_per_beat(input logic [1:0] mode, input int unsigned out_w);
    case (mode)
      MODE_HALF:   lanes_per_beat = out_w / 16;
      MODE_SINGLE: lanes_per_beat = out_w / 32;
      default:     lanes_per_beat = out_w / 64;
    endcase
  endfunction

  // Code 3 is an alias of double; folding it here keeps every decoder three-way.
  function automatic logic [1:0] norm_mode(input logic [1:0] ctrl);
    return (ctrl == 2'd3) ? MODE_DOUBLE : ctrl;
  endfunction

endpackage

// File: rtl/spmv_result_packer_if.sv
// Stream bundle of the result packer: three precision input streams and the packed AXIS output.
interface spmv_result_packer_if #(
  parameter int OUT_W = 512
);
  logic              s_double_valid;
  logic              s_double_ready;
  logic [63:0]       s_double_data;
  logic              s_single_valid;
  logic              s_single_ready;
  logic [31:0]       s_single_data;
  logic              s_half_valid;
  logic              s_half_ready;
  logic [15:0]       s_half_data;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [OUT_W/8-1:0] m_axis_tkeep;
  logic              m_axis_tlast;

  modport master (
    input  s_double_valid, s_double_data, s_single_valid, s_single_data,
           s_half_valid, s_half_data, m_axis_tready,
    output s_double_ready, s_single_ready, s_half_ready,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport slave (
    output s_double_valid, s_double_data, s_single_valid, s_single_data,
           s_half_valid, s_half_data, m_axis_tready,
    input  s_double_ready, s_single_ready, s_half_ready,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/spmv_result_packer_out_reg.sv
// Single-entry AXIS output register; holds data/keep/last stable until the beat is taken.
module spmv_pack_out_reg #(
  parameter int OUT_W = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [OUT_W-1:0]   ld_data,
  input  logic [OUT_W/8-1:0] ld_keep,
  input  logic               ld_last,
  input  logic               tready,
  output logic               tvalid,
  output logic [OUT_W-1:0]   tdata,
  output logic [OUT_W/8-1:0] tkeep,
  output logic               tlast
);

  // load is only raised when the slot is free, so it may overwrite unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= ld_data;
      tkeep  <= ld_keep;
      tlast  <= ld_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/spmv_result_packer.sv
// Packs double/single/half results into OUT_W-bit AXIS beats with tlast and zero padding.
// Optional beat/stall statistics are built when SPMV_PACK_STATS_EN is defined.
module spmv_result_packer
  import spmv_pack_pkg::*;
#(
  parameter int OUT_W = 512,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Ctrl_sig,
  input  logic             start,
  input  logic [CNT_W-1:0] total_cnt,
  output logic             busy,
  output logic             done,
  spmv_result_packer_if.master io,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stalls
);

  localparam int KW  = OUT_W / 8;
  localparam int LW  = $clog2(OUT_W / 16);
  localparam int NBW = $clog2(KW) + 1;

  state_t           state, state_nx;
  logic [1:0]       mode;
  logic [CNT_W-1:0] total, elem_cnt;
  logic [LW-1:0]    lane, lane_max;
  logic [OUT_W-1:0] acc, acc_nx;
  logic [KW-1:0]    keep_nx;
  logic [NBW-1:0]   nbytes;
  logic [63:0]      in_data;
  logic             in_valid, in_ready, accept;
  logic             last_elem, completing, out_free, load;

  always_comb begin
    in_valid = io.s_double_valid;
    in_data  = io.s_double_data;
    case (mode)
      MODE_HALF: begin
        in_valid = io.s_half_valid;
        in_data  = {48'b0, io.s_half_data};
      end
      MODE_SINGLE: begin
        in_valid = io.s_single_valid;
        in_data  = {32'b0, io.s_single_data};
      end
      default: ;
    endcase
  end

  assign lane_max   = LW'(lanes_per_beat(mode, OUT_W) - 1);
  assign last_elem  = (elem_cnt == total - CNT_W'(1));
  assign completing = (lane == lane_max) | last_elem;
  assign out_free   = !io.m_axis_tvalid | io.m_axis_tready;
  // A word-completing element may only enter when the output slot can take the word.
  assign in_ready   = (state == ST_PACK) & (!completing | out_free);
  assign accept     = in_ready & in_valid;
  assign load       = accept & completing;

  assign io.s_half_ready   = in_ready & (mode == MODE_HALF);
  assign io.s_single_ready = in_ready & (mode == MODE_SINGLE);
  assign io.s_double_ready = in_ready & (mode == MODE_DOUBLE);

  always_comb begin
    acc_nx = acc;
    nbytes = '0;
    case (mode)
      MODE_HALF: begin
        acc_nx[lane*16 +: 16] = in_data[15:0];
        nbytes = NBW'((32'(lane) + 32'd1) * 32'd2);
      end
      MODE_SINGLE: begin
        acc_nx[lane*32 +: 32] = in_data[31:0];
        nbytes = NBW'((32'(lane) + 32'd1) * 32'd4);
      end
      default: begin
        acc_nx[lane*64 +: 64] = in_data;
        nbytes = NBW'((32'(lane) + 32'd1) * 32'd8);
      end
    endcase
    for (int b = 0; b < KW; b++) begin
      keep_nx[b] = (b < int'(nbytes));
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = (total_cnt == '0) ? ST_FIN : ST_PACK;
      ST_PACK: begin
        busy = 1'b1;
        if (accept && last_elem) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (io.m_axis_tvalid && io.m_axis_tready) state_nx = ST_FIN;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode     <= MODE_HALF;
      total    <= '0;
      elem_cnt <= '0;
      lane     <= '0;
      acc      <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        mode     <= norm_mode(Ctrl_sig);
        total    <= total_cnt;
        elem_cnt <= '0;
        lane     <= '0;
        acc      <= '0;
      end else if (accept) begin
        elem_cnt <= elem_cnt + CNT_W'(1);
        if (completing) begin
          lane <= '0;
          acc  <= '0;
        end else begin
          lane <= lane + LW'(1);
          acc  <= acc_nx;
        end
      end
    end
  end

  spmv_pack_out_reg #(.OUT_W(OUT_W)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ld_data (acc_nx),
    .ld_keep (keep_nx),
    .ld_last (last_elem),
    .tready  (io.m_axis_tready),
    .tvalid  (io.m_axis_tvalid),
    .tdata   (io.m_axis_tdata),
    .tkeep   (io.m_axis_tkeep),
    .tlast   (io.m_axis_tlast)
  );

`ifdef SPMV_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && start)) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (io.m_axis_tvalid && io.m_axis_tready && stat_beats != '1)
        stat_beats <= stat_beats + 32'd1;
      if (io.m_axis_tvalid && !io.m_axis_tready && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule
